// File: rtl/msg_pkg.sv
// Shared types and defaults for the message FIFO hub.
package msg_pkg;

  localparam int unsigned W_MSG_DEF  = 64;
  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned W_CH_MAX   = 4;

  typedef logic [W_MSG_DEF-1:0] msg_t;

  typedef struct packed {
    logic [W_CH_MAX-1:0] ch;
    msg_t                msg;
  } tagged_msg_t;

  function automatic int unsigned ch_width(input int unsigned n_ch);
    return (n_ch > 32'd1) ? unsigned'($clog2(n_ch)) : 32'd1;
  endfunction

endpackage

// File: rtl/msg_fifo_hub_if.sv
// Client-side and NoC-side handshake bundle of the message FIFO hub.
interface msg_fifo_hub_if
  import msg_pkg::*;
#(
  parameter int unsigned W_MSG = W_MSG_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned N_CH  = 4
);
  localparam int unsigned W_CH  = ch_width(N_CH);
  localparam int unsigned W_CNT = $clog2(DEPTH) + 1;

  logic [N_CH-1:0]             i_out_msg_rdy;
  logic [N_CH-1:0][W_MSG-1:0]  i_out_msg;
  logic [N_CH-1:0]             i_out_msg_ack;
  logic                        o_out_msg_rdy;
  logic [W_MSG-1:0]            o_out_msg;
  logic [W_CH-1:0]             o_out_ch;
  logic                        o_out_msg_ack;
  logic                        o_in_msg_rdy;
  logic [W_MSG-1:0]            o_in_msg;
  logic [W_CH-1:0]             o_in_ch;
  logic                        o_in_msg_ack;
  logic [N_CH-1:0]             i_in_msg_rdy;
  logic [N_CH-1:0][W_MSG-1:0]  i_in_msg;
  logic [N_CH-1:0]             i_in_msg_ack;
  logic [W_CNT-1:0]            out_count;
  logic [N_CH-1:0][W_CNT-1:0]  in_count;
  logic                        err_bad_ch;

  // Hub side.
  modport slave (
    input  i_out_msg_rdy, i_out_msg, o_out_msg_ack, o_in_msg_rdy, o_in_msg, o_in_ch,
           i_in_msg_ack,
    output i_out_msg_ack, o_out_msg_rdy, o_out_msg, o_out_ch, o_in_msg_ack, i_in_msg_rdy,
           i_in_msg, out_count, in_count, err_bad_ch
  );

  // Clients and NoC link side.
  modport master (
    output i_out_msg_rdy, i_out_msg, o_out_msg_ack, o_in_msg_rdy, o_in_msg, o_in_ch,
           i_in_msg_ack,
    input  i_out_msg_ack, o_out_msg_rdy, o_out_msg, o_out_ch, o_in_msg_ack, i_in_msg_rdy,
           i_in_msg, out_count, in_count, err_bad_ch
  );

endinterface

// File: rtl/msg_fifo.sv
// Synchronous FIFO with registered occupancy; storage is not reset.
module msg_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned W_CNT = AW + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [W_CNT-1:0] count_q;
  logic             do_push, do_pop;

  // Full/empty come from the registered count, so a same-cycle pop never frees a slot.
  assign full    = (count_q == W_CNT'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + W_CNT'(1);
        2'b01:   count_q <= count_q - W_CNT'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/msg_fifo_hub.sv
// N_CH clients to one NoC link: round-robin shared outbound FIFO, tag-routed inbound FIFOs.
module msg_fifo_hub
  import msg_pkg::*;
#(
  parameter int unsigned W_MSG = W_MSG_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned N_CH  = 4
) (
  input logic           clk,
  input logic           rst,
  msg_fifo_hub_if.slave bus
);
  localparam int unsigned W_CH  = ch_width(N_CH);
  localparam int unsigned W_CNT = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [W_CH-1:0]  ch;
    logic [W_MSG-1:0] msg;
  } out_ent_t;

  logic [N_CH-1:0]            out_ack_q, out_ack_d;
  logic [W_CH-1:0]            rr_ptr_q, rr_ptr_d;
  logic                       in_ack_q, in_ack_d;
  logic                       err_q, err_d;

  logic [N_CH-1:0]            elig;
  logic                       grant_valid;
  logic [W_CH-1:0]            grant_idx, idx;
  out_ent_t                   out_din, out_dout;
  logic                       out_full, out_empty;
  logic [W_CNT-1:0]           out_cnt;

  logic                       in_valid, bad_ch, tgt_full;
  logic [N_CH-1:0]            in_push, in_full, in_empty;
  logic [N_CH-1:0][W_MSG-1:0] in_dout;
  logic [N_CH-1:0][W_CNT-1:0] in_cnt;

  // Round-robin search starting at rr_ptr_q; a client with an ack in flight is skipped.
  always_comb begin
    elig        = bus.i_out_msg_rdy & ~out_ack_q;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = W_CH'((32'(rr_ptr_q) + k) % N_CH);
      if (!grant_valid && !out_full && elig[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
    out_ack_d = '0;
    if (grant_valid) out_ack_d[grant_idx] = 1'b1;
    rr_ptr_d    = grant_valid ? W_CH'((32'(grant_idx) + 32'd1) % N_CH) : rr_ptr_q;
    out_din.ch  = grant_idx;
    out_din.msg = bus.i_out_msg[grant_idx];
  end

  // Only tags that can encode a value >= N_CH need the out-of-range check.
  if ((1 << W_CH) > N_CH) begin : g_bad_ch
    assign bad_ch = (bus.o_in_ch >= W_CH'(N_CH));
  end else begin : g_no_bad_ch
    assign bad_ch = 1'b0;
  end

  always_comb begin
    in_valid = bus.o_in_msg_rdy & ~in_ack_q;
    tgt_full = 1'b0;
    in_push  = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (bus.o_in_ch == W_CH'(c)) begin
        tgt_full   = in_full[c];
        in_push[c] = in_valid & ~bad_ch & ~in_full[c];
      end
    end
    in_ack_d = in_valid & (bad_ch | ~tgt_full);
    err_d    = err_q | (in_valid & bad_ch);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_ack_q <= '0;
      rr_ptr_q  <= '0;
      in_ack_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      out_ack_q <= out_ack_d;
      rr_ptr_q  <= rr_ptr_d;
      in_ack_q  <= in_ack_d;
      err_q     <= err_d;
    end
  end

  msg_fifo #(
    .W     ($bits(out_ent_t)),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant_valid),
    .pop   (bus.o_out_msg_ack),
    .din   (out_din),
    .dout  (out_dout),
    .full  (out_full),
    .empty (out_empty),
    .count (out_cnt)
  );

  for (genvar c = 0; c < N_CH; c++) begin : g_in_fifo
    msg_fifo #(
      .W     (W_MSG),
      .DEPTH (DEPTH)
    ) u_in_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_push[c]),
      .pop   (bus.i_in_msg_ack[c]),
      .din   (bus.o_in_msg),
      .dout  (in_dout[c]),
      .full  (in_full[c]),
      .empty (in_empty[c]),
      .count (in_cnt[c])
    );
  end

  assign bus.i_out_msg_ack = out_ack_q;
  assign bus.o_out_msg_rdy = ~out_empty;
  assign bus.o_out_msg     = out_dout.msg;
  assign bus.o_out_ch      = out_dout.ch;
  assign bus.o_in_msg_ack  = in_ack_q;
  assign bus.i_in_msg_rdy  = ~in_empty;
  assign bus.i_in_msg      = in_dout;
  assign bus.out_count     = out_cnt;
  assign bus.in_count      = in_cnt;
  assign bus.err_bad_ch    = err_q;

endmodule

// File: tb/tb_msg_fifo_hub.sv
// Directed bench for msg_fifo_hub: a 4-channel hub for most cases, a 3-channel hub for bad tags.
module tb_msg_fifo_hub;

  logic clk = 1'b0;
  logic rst4, rst3;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  msg_fifo_hub_if #(.W_MSG(16), .DEPTH(8), .N_CH(4)) bus4 ();
  msg_fifo_hub_if #(.W_MSG(16), .DEPTH(8), .N_CH(3)) bus3 ();

  msg_fifo_hub #(.W_MSG(16), .DEPTH(8), .N_CH(4)) u_hub4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  msg_fifo_hub #(.W_MSG(16), .DEPTH(8), .N_CH(3)) u_hub3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  typedef struct {
    logic        rdy;
    logic [1:0]  ch;
    logic [15:0] msg;
    logic [3:0]  pop;
    logic        exp_ack;
    logic [3:0]  exp_rdy;
    logic [15:0] exp_cnt;
    int          hd_ch;
    logic [15:0] hd_val;
  } vec_t;

  vec_t vt[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic out_send(input int c, input logic [15:0] data);
    bit ok = 1'b0;
    bus4.i_out_msg_rdy[c] = 1'b1;
    bus4.i_out_msg[c]     = data;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus4.i_out_msg_ack[c]) begin
        ok = 1'b1;
        break;
      end
    end
    bus4.i_out_msg_rdy[c] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL out_send_timeout: got no ack expected ack for client %0d", c);
    end
  endtask

  task automatic in_send(input logic [1:0] ch, input logic [15:0] data);
    bit ok = 1'b0;
    bus4.o_in_msg_rdy = 1'b1;
    bus4.o_in_ch      = ch;
    bus4.o_in_msg     = data;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus4.o_in_msg_ack) begin
        ok = 1'b1;
        break;
      end
    end
    bus4.o_in_msg_rdy = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL in_send_timeout: got no ack expected ack for ch %0d", ch);
    end
  endtask

  initial begin
    // rdy, ch, msg, pop, exp_ack, exp_rdy, exp_cnt {c3,c2,c1,c0}, head channel, head value
    vt[0] = '{1'b1, 2'd2, 16'h0011, 4'b0000, 1'b1, 4'b0100, 16'h0100, 2, 16'h0011};
    vt[1] = '{1'b1, 2'd0, 16'h0022, 4'b0000, 1'b0, 4'b0100, 16'h0100, 2, 16'h0011};
    vt[2] = '{1'b1, 2'd0, 16'h0022, 4'b0000, 1'b1, 4'b0101, 16'h0101, 0, 16'h0022};
    vt[3] = '{1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0, 4'b0101, 16'h0101, 0, 16'h0022};
    vt[4] = '{1'b1, 2'd2, 16'h0033, 4'b0000, 1'b1, 4'b0101, 16'h0201, 2, 16'h0011};
    vt[5] = '{1'b0, 2'd0, 16'h0000, 4'b0100, 1'b0, 4'b0101, 16'h0101, 2, 16'h0033};
    vt[6] = '{1'b1, 2'd1, 16'h0044, 4'b0001, 1'b1, 4'b0110, 16'h0110, 1, 16'h0044};
    vt[7] = '{1'b0, 2'd0, 16'h0000, 4'b1010, 1'b0, 4'b0100, 16'h0100, 2, 16'h0033};
    vt[8] = '{1'b0, 2'd0, 16'h0000, 4'b0100, 1'b0, 4'b0000, 16'h0000, 2, 16'h0000};

    bus4.i_out_msg_rdy = '0; bus4.i_out_msg = '0; bus4.o_out_msg_ack = 1'b0;
    bus4.o_in_msg_rdy  = 1'b0; bus4.o_in_msg = '0; bus4.o_in_ch = '0; bus4.i_in_msg_ack = '0;
    bus3.i_out_msg_rdy = '0; bus3.i_out_msg = '0; bus3.o_out_msg_ack = 1'b0;
    bus3.o_in_msg_rdy  = 1'b0; bus3.o_in_msg = '0; bus3.o_in_ch = '0; bus3.i_in_msg_ack = '0;
    rst4 = 1'b1;
    rst3 = 1'b1;
    tick();
    tick();
    rst4 = 1'b0;
    rst3 = 1'b0;

    chk("rst_out_ack",   64'(bus4.i_out_msg_ack), 64'(0));
    chk("rst_out_rdy",   64'(bus4.o_out_msg_rdy), 64'(0));
    chk("rst_in_ack",    64'(bus4.o_in_msg_ack),  64'(0));
    chk("rst_in_rdy",    64'(bus4.i_in_msg_rdy),  64'(0));
    chk("rst_out_count", 64'(bus4.out_count),     64'(0));
    chk("rst_in_count",  64'(bus4.in_count),      64'(0));
    chk("rst_err",       64'(bus4.err_bad_ch),    64'(0));

    // Inbound routing, back-to-back refusal, client pops.
    for (int r = 0; r < 9; r++) begin
      bus4.o_in_msg_rdy = vt[r].rdy;
      bus4.o_in_ch      = vt[r].ch;
      bus4.o_in_msg     = vt[r].msg;
      bus4.i_in_msg_ack = vt[r].pop;
      tick();
      chk($sformatf("vec%0d_in_ack", r),   64'(bus4.o_in_msg_ack), 64'(vt[r].exp_ack));
      chk($sformatf("vec%0d_in_rdy", r),   64'(bus4.i_in_msg_rdy), 64'(vt[r].exp_rdy));
      chk($sformatf("vec%0d_in_count", r), 64'(bus4.in_count),     64'(vt[r].exp_cnt));
      if (vt[r].exp_rdy[vt[r].hd_ch])
        chk($sformatf("vec%0d_head", r), 64'(bus4.i_in_msg[vt[r].hd_ch]), 64'(vt[r].hd_val));
    end
    bus4.o_in_msg_rdy = 1'b0;
    bus4.i_in_msg_ack = '0;

    // Outbound round robin: four clients request together.
    bus4.i_out_msg_rdy = 4'b1111;
    for (int k = 0; k < 4; k++) bus4.i_out_msg[k] = 16'(16'h00A0 + k);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rr_ack%0d", k),   64'(bus4.i_out_msg_ack), 64'(1 << k));
      chk($sformatf("rr_count%0d", k), 64'(bus4.out_count),     64'(k + 1));
      bus4.i_out_msg_rdy[k] = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_head_ch%0d", k),  64'(bus4.o_out_ch),  64'(k));
      chk($sformatf("rr_head_msg%0d", k), 64'(bus4.o_out_msg), 64'(16'h00A0 + k));
      bus4.o_out_msg_ack = 1'b1;
      tick();
      bus4.o_out_msg_ack = 1'b0;
    end
    chk("rr_drained_rdy",   64'(bus4.o_out_msg_rdy), 64'(0));
    chk("rr_drained_count", 64'(bus4.out_count),     64'(0));

    // Outbound full: ninth request waits for a free slot.
    for (int i = 0; i < 8; i++) out_send(0, 16'(16'h0100 + i));
    chk("full_count", 64'(bus4.out_count), 64'(8));
    bus4.i_out_msg_rdy[1] = 1'b1;
    bus4.i_out_msg[1]     = 16'h00B1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("full_noack%0d", i), 64'(bus4.i_out_msg_ack[1]), 64'(0));
      chk($sformatf("full_hold%0d", i),  64'(bus4.out_count),        64'(8));
    end
    bus4.o_out_msg_ack = 1'b1;
    tick();
    bus4.o_out_msg_ack = 1'b0;
    chk("full_pop_noack", 64'(bus4.i_out_msg_ack[1]), 64'(0));
    chk("full_pop_count", 64'(bus4.out_count),        64'(7));
    tick();
    chk("full_late_ack",   64'(bus4.i_out_msg_ack[1]), 64'(1));
    chk("full_late_count", 64'(bus4.out_count),        64'(8));
    bus4.i_out_msg_rdy[1] = 1'b0;
    chk("full_head", 64'(bus4.o_out_msg), 64'(16'h0101));
    bus4.o_out_msg_ack = 1'b1;
    repeat (8) tick();
    bus4.o_out_msg_ack = 1'b0;
    chk("full_drained", 64'(bus4.out_count), 64'(0));

    // Inbound full with a same-cycle client pop.
    for (int i = 0; i < 8; i++) in_send(2'd3, 16'(16'h0300 + i));
    chk("infull_count", 64'(bus4.in_count[3]), 64'(8));
    bus4.o_in_msg_rdy = 1'b1;
    bus4.o_in_ch      = 2'd3;
    bus4.o_in_msg     = 16'h0399;
    bus4.i_in_msg_ack = 4'b1000;
    tick();
    bus4.i_in_msg_ack = '0;
    chk("infull_refused", 64'(bus4.o_in_msg_ack), 64'(0));
    chk("infull_pop7",    64'(bus4.in_count[3]),  64'(7));
    tick();
    bus4.o_in_msg_rdy = 1'b0;
    chk("infull_accept", 64'(bus4.o_in_msg_ack), 64'(1));
    chk("infull_back8",  64'(bus4.in_count[3]),  64'(8));
    chk("infull_head",   64'(bus4.i_in_msg[3]),  64'(16'h0301));
    bus4.i_in_msg_ack = 4'b1000;
    repeat (8) tick();
    bus4.i_in_msg_ack = '0;
    chk("infull_drained", 64'(bus4.in_count[3]), 64'(0));

    // Reset with five outbound entries and an ack pending.
    for (int i = 0; i < 4; i++) out_send(0, 16'(16'h0200 + i));
    bus4.i_out_msg_rdy[2] = 1'b1;
    bus4.i_out_msg[2]     = 16'h00C0;
    tick();
    chk("pre_rst_ack",   64'(bus4.i_out_msg_ack), 64'(4'b0100));
    chk("pre_rst_count", 64'(bus4.out_count),     64'(5));
    bus4.i_out_msg_rdy[2] = 1'b0;
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    chk("mid_rst_ack",   64'(bus4.i_out_msg_ack), 64'(0));
    chk("mid_rst_rdy",   64'(bus4.o_out_msg_rdy), 64'(0));
    chk("mid_rst_count", 64'(bus4.out_count),     64'(0));
    bus4.i_out_msg_rdy[2] = 1'b1;
    bus4.i_out_msg[2]     = 16'h00C2;
    tick();
    bus4.i_out_msg_rdy[2] = 1'b0;
    chk("post_rst_ack",   64'(bus4.i_out_msg_ack), 64'(4'b0100));
    chk("post_rst_ch",    64'(bus4.o_out_ch),      64'(2));
    chk("post_rst_msg",   64'(bus4.o_out_msg),     64'(16'h00C2));
    chk("post_rst_count", 64'(bus4.out_count),     64'(1));

    // Bad tag on the 3-channel hub.
    chk("bad_err_init", 64'(bus3.err_bad_ch), 64'(0));
    bus3.o_in_msg_rdy = 1'b1;
    bus3.o_in_ch      = 2'd3;
    bus3.o_in_msg     = 16'h0055;
    tick();
    bus3.o_in_msg_rdy = 1'b0;
    chk("bad_ack",    64'(bus3.o_in_msg_ack), 64'(1));
    chk("bad_err",    64'(bus3.err_bad_ch),   64'(1));
    chk("bad_counts", 64'(bus3.in_count),     64'(0));
    tick();
    tick();
    chk("bad_ack_once",   64'(bus3.o_in_msg_ack), 64'(0));
    chk("bad_err_sticky", 64'(bus3.err_bad_ch),   64'(1));
    bus3.o_in_msg_rdy = 1'b1;
    bus3.o_in_ch      = 2'd1;
    bus3.o_in_msg     = 16'h0066;
    tick();
    bus3.o_in_msg_rdy = 1'b0;
    chk("good_ack",    64'(bus3.o_in_msg_ack), 64'(1));
    chk("good_rdy",    64'(bus3.i_in_msg_rdy), 64'(3'b010));
    chk("good_head",   64'(bus3.i_in_msg[1]),  64'(16'h0066));
    chk("good_err",    64'(bus3.err_bad_ch),   64'(1));
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    chk("bad_err_rst", 64'(bus3.err_bad_ch),   64'(0));
    chk("bad_rdy_rst", 64'(bus3.i_in_msg_rdy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
